// File: rtl/uart_paket.sv
// Shared UART definitions: state encodings, data width and default counter width.
// Used by both the receiver and the transmitter.
package uart_paket;

    localparam int VERI_W             = 8;
    localparam int SAYAC_W_VARSAYILAN = 16;
    localparam int BIT_IDX_W          = $clog2(VERI_W);
    localparam logic [BIT_IDX_W-1:0] SON_BIT_IDX = BIT_IDX_W'(VERI_W - 1);

    typedef enum logic [2:0] {
        BOSTA = 3'd0,
        BASLA = 3'd1,
        VERI  = 3'd2,
        DUR   = 3'd3,
        HATA  = 3'd4
    } durum_t;

endpackage

// File: rtl/uart_senkronizor.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
// Both flops reset to RESET_DEGERI so an idle-high line stays quiet through reset.
module uart_senkronizor #(
    parameter logic RESET_DEGERI = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic asenk_i,
    output logic senk_o
);

    logic ara;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ara    <= RESET_DEGERI;
            senk_o <= RESET_DEGERI;
        end else begin
            ara    <= asenk_i;
            senk_o <= ara;
        end
    end

endmodule

// File: rtl/uart_alici.sv
// 8N1 UART receiver: start-bit qualification at half period, mid-bit sampling,
// and a valid/acknowledge handshake with frame-error and overrun pulses.
module uart_alici
    import uart_paket::*;
#(
    parameter int SAYAC_W = SAYAC_W_VARSAYILAN
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_i,
    input  logic [SAYAC_W-1:0] baud_div_i,
    input  logic               alindi_i,
    output logic [VERI_W-1:0]  veri_o,
    output logic               veri_gecerli_o,
    output logic               cerceve_hata_o,
    output logic               tasma_o,
    output logic               mesgul_o
);

    logic                 rx_s;
    durum_t               durum, durum_sonraki;
    logic [SAYAC_W-1:0]   sayac, sayac_sonraki;
    logic [BIT_IDX_W-1:0] bit_idx, bit_idx_sonraki;
    logic [VERI_W-1:0]    kaydirma, kaydirma_sonraki;
    logic [SAYAC_W-1:0]   yari_periyot;
    logic                 periyot_sonu;
    logic                 yari_sonu;
    logic                 bayt_tamam;
    logic                 cerceve_hata;

    uart_senkronizor #(
        .RESET_DEGERI (1'b1)
    ) u_rx_senk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .asenk_i (rx_i),
        .senk_o  (rx_s)
    );

    assign yari_periyot = baud_div_i >> 1;
    assign periyot_sonu = (sayac == baud_div_i);
    assign yari_sonu    = (sayac == yari_periyot);
    assign mesgul_o     = (durum != BOSTA);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum    <= BOSTA;
            sayac    <= '0;
            bit_idx  <= '0;
            kaydirma <= '0;
        end else begin
            durum    <= durum_sonraki;
            sayac    <= sayac_sonraki;
            bit_idx  <= bit_idx_sonraki;
            kaydirma <= kaydirma_sonraki;
        end
    end

    always_comb begin
        durum_sonraki    = durum;
        sayac_sonraki    = sayac;
        bit_idx_sonraki  = bit_idx;
        kaydirma_sonraki = kaydirma;
        bayt_tamam       = 1'b0;
        cerceve_hata     = 1'b0;

        unique case (durum)
            BOSTA: begin
                sayac_sonraki   = '0;
                bit_idx_sonraki = '0;
                if (!rx_s) begin
                    durum_sonraki = BASLA;
                end
            end

            // A start bit that is high again by mid-bit is a glitch and is dropped.
            BASLA: begin
                if (yari_sonu) begin
                    sayac_sonraki = '0;
                    durum_sonraki = rx_s ? BOSTA : VERI;
                end else begin
                    sayac_sonraki = sayac + SAYAC_W'(1);
                end
            end

            VERI: begin
                if (periyot_sonu) begin
                    sayac_sonraki    = '0;
                    kaydirma_sonraki = {rx_s, kaydirma[VERI_W-1:1]};
                    if (bit_idx == SON_BIT_IDX) begin
                        bit_idx_sonraki = '0;
                        durum_sonraki   = DUR;
                    end else begin
                        bit_idx_sonraki = bit_idx + BIT_IDX_W'(1);
                    end
                end else begin
                    sayac_sonraki = sayac + SAYAC_W'(1);
                end
            end

            DUR: begin
                if (periyot_sonu) begin
                    sayac_sonraki = '0;
                    if (rx_s) begin
                        bayt_tamam    = 1'b1;
                        durum_sonraki = BOSTA;
                    end else begin
                        cerceve_hata  = 1'b1;
                        durum_sonraki = HATA;
                    end
                end else begin
                    sayac_sonraki = sayac + SAYAC_W'(1);
                end
            end

            // Stuck-low line: wait for idle before looking for a new start bit.
            HATA: begin
                sayac_sonraki = '0;
                if (rx_s) begin
                    durum_sonraki = BOSTA;
                end
            end

            default: begin
                durum_sonraki = BOSTA;
                sayac_sonraki = '0;
            end
        endcase
    end

    // A completed byte takes priority over the acknowledge, so valid stays high
    // when both coincide; overrun only when the old byte was never acknowledged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            veri_o         <= '0;
            veri_gecerli_o <= 1'b0;
            cerceve_hata_o <= 1'b0;
            tasma_o        <= 1'b0;
        end else begin
            cerceve_hata_o <= cerceve_hata;
            tasma_o        <= 1'b0;
            if (bayt_tamam) begin
                veri_o         <= kaydirma;
                veri_gecerli_o <= 1'b1;
                tasma_o        <= veri_gecerli_o && !alindi_i;
            end else if (alindi_i) begin
                veri_gecerli_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_alici.sv
// Self-checking bench for uart_alici: frame-level event model compared every cycle,
// plus directed literal checks for latency, glitch, frame error, overrun and reset.
module tb_uart_alici;

    logic        clk_i      = 1'b0;
    logic        rst_i      = 1'b1;
    logic        rx_i       = 1'b1;
    logic        alindi_i   = 1'b0;
    logic [15:0] baud_div_i = 16'd15;
    logic [7:0]  veri_o;
    logic        veri_gecerli_o;
    logic        cerceve_hata_o;
    logic        tasma_o;
    logic        mesgul_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         at;
        logic [7:0] d;
        bit         ok;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] m_veri  = '0;
    logic       m_gec   = 1'b0;
    logic       m_hata  = 1'b0;
    logic       m_tasma = 1'b0;
    bit         cmp_en  = 1'b0;

    int         tasma_say = 0;
    int         hata_say  = 0;
    int         rise_cyc  = -1;
    logic       prev_gec  = 1'b0;
    logic [7:0] alinan[$];

    always #5 clk_i = ~clk_i;

    uart_alici #(
        .SAYAC_W (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .baud_div_i     (baud_div_i),
        .alindi_i       (alindi_i),
        .veri_o         (veri_o),
        .veri_gecerli_o (veri_gecerli_o),
        .cerceve_hata_o (cerceve_hata_o),
        .tasma_o        (tasma_o),
        .mesgul_o       (mesgul_o)
    );

    // Frame-level model: each transmitted frame is an event at its stop-sample edge.
    always @(posedge clk_i) begin
        ev_t e;
        cyc     = cyc + 1;
        m_hata  = 1'b0;
        m_tasma = 1'b0;
        if (rst_i) begin
            m_veri = '0;
            m_gec  = 1'b0;
            evq.delete();
        end else if (evq.size() > 0 && evq[0].at == cyc) begin
            e = evq.pop_front();
            if (e.ok) begin
                m_tasma = m_gec && !alindi_i;
                m_gec   = 1'b1;
                m_veri  = e.d;
            end else begin
                m_hata = 1'b1;
                if (alindi_i) m_gec = 1'b0;
            end
        end else if (alindi_i) begin
            m_gec = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            tests = tests + 1;
            if ({veri_o, veri_gecerli_o, cerceve_hata_o, tasma_o} !== {m_veri, m_gec, m_hata, m_tasma}) begin
                fails = fails + 1;
                $display("[TB] FAIL model_cmp cyc=%0d got veri=%h gec=%b hata=%b tasma=%b, want veri=%h gec=%b hata=%b tasma=%b",
                         cyc, veri_o, veri_gecerli_o, cerceve_hata_o, tasma_o, m_veri, m_gec, m_hata, m_tasma);
            end
            if (tasma_o === 1'b1) tasma_say = tasma_say + 1;
            if (cerceve_hata_o === 1'b1) hata_say = hata_say + 1;
            if (veri_gecerli_o === 1'b1 && prev_gec === 1'b0 && rise_cyc < 0) rise_cyc = cyc;
            prev_gec = veri_gecerli_o;
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("[TB] FAIL %s got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic driveBit(input logic b, input int per);
        rx_i = b;
        repeat (per) @(negedge clk_i);
    endtask

    // Sends one 8N1 frame starting at the current negedge and registers its model event.
    task automatic applyStimulus(input logic [7:0] d, input logic stop_bit);
        int  per;
        ev_t e;
        per  = int'(baud_div_i) + 1;
        e.at = cyc + 4 + (int'(baud_div_i) >> 1) + 9 * per;
        e.d  = d;
        e.ok = stop_bit;
        evq.push_back(e);
        driveBit(1'b0, per);
        for (int i = 0; i < 8; i++) driveBit(d[i], per);
        driveBit(stop_bit, per);
    endtask

    task automatic ackOnce();
        alindi_i = 1'b1;
        @(negedge clk_i);
        alindi_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic ackForCycles(input int n);
        repeat (n) begin
            @(negedge clk_i);
            if (veri_gecerli_o === 1'b1 && alindi_i === 1'b0) begin
                alinan.push_back(veri_o);
                alindi_i = 1'b1;
            end else begin
                alindi_i = 1'b0;
            end
        end
        alindi_i = 1'b0;
    endtask

    task automatic loopback(input logic [15:0] bd, input string nm);
        int t0, h0, per;
        baud_div_i = bd;
        per        = int'(bd) + 1;
        repeat (4) @(negedge clk_i);
        alinan.delete();
        t0 = tasma_say;
        h0 = hata_say;
        fork
            begin
                applyStimulus(8'h00, 1'b1);
                applyStimulus(8'hFF, 1'b1);
                applyStimulus(8'h55, 1'b1);
            end
            ackForCycles(30 * per + 40);
        join
        checkOutput({nm, "_count"}, 32'(alinan.size()), 32'd3);
        if (alinan.size() == 3) begin
            checkOutput({nm, "_b0"}, 32'(alinan[0]), 32'h00);
            checkOutput({nm, "_b1"}, 32'(alinan[1]), 32'hFF);
            checkOutput({nm, "_b2"}, 32'(alinan[2]), 32'h55);
        end
        checkOutput({nm, "_errors"}, 32'((tasma_say - t0) + (hata_say - h0)), 32'd0);
    endtask

    initial begin
        int st, t0, h0, per;

        @(negedge clk_i);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_veri", 32'(veri_o), 32'd0);
        checkOutput("reset_gecerli", 32'(veri_gecerli_o), 32'd0);
        checkOutput("reset_mesgul", 32'(mesgul_o), 32'd0);

        // 1) 0xA5 at baud_div 15: valid 4+7+9*16 = 155 cycles after the start bit is driven
        rise_cyc = -1;
        st = cyc;
        applyStimulus(8'hA5, 1'b1);
        repeat (5) @(negedge clk_i);
        checkOutput("t1_data", 32'(veri_o), 32'hA5);
        checkOutput("t1_rise_latency", 32'(rise_cyc - st), 32'd155);
        checkOutput("t1_no_err", 32'(tasma_say + hata_say), 32'd0);
        ackOnce();
        checkOutput("t1_ack_clears", 32'(veri_gecerli_o), 32'd0);

        // 2) short low glitch is dropped, next frame still received
        rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (30) @(negedge clk_i);
        checkOutput("t2_glitch_valid", 32'(veri_gecerli_o), 32'd0);
        checkOutput("t2_glitch_busy", 32'(mesgul_o), 32'd0);
        checkOutput("t2_glitch_hata", 32'(hata_say), 32'd0);
        applyStimulus(8'h3C, 1'b1);
        repeat (4) @(negedge clk_i);
        checkOutput("t2_data", 32'(veri_o), 32'h3C);
        checkOutput("t2_valid", 32'(veri_gecerli_o), 32'd1);
        ackOnce();

        // 3) stop bit low, line held low
        h0 = hata_say;
        applyStimulus(8'h3C, 1'b0);
        repeat (40) @(negedge clk_i);
        checkOutput("t3_hata_pulses", 32'(hata_say - h0), 32'd1);
        checkOutput("t3_valid", 32'(veri_gecerli_o), 32'd0);
        checkOutput("t3_busy_in_hata", 32'(mesgul_o), 32'd1);
        rx_i = 1'b1;
        repeat (6) @(negedge clk_i);
        checkOutput("t3_idle_after_high", 32'(mesgul_o), 32'd0);

        // 4) overrun, then acknowledge in the completion cycle
        t0 = tasma_say;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        repeat (5) @(negedge clk_i);
        checkOutput("t4_tasma_pulses", 32'(tasma_say - t0), 32'd1);
        checkOutput("t4_data", 32'(veri_o), 32'h22);
        checkOutput("t4_valid", 32'(veri_gecerli_o), 32'd1);
        ackOnce();
        applyStimulus(8'h11, 1'b1);
        t0 = tasma_say;
        fork
            applyStimulus(8'h22, 1'b1);
            begin
                repeat (154) @(negedge clk_i);
                alindi_i = 1'b1;
                @(negedge clk_i);
                alindi_i = 1'b0;
            end
        join
        repeat (5) @(negedge clk_i);
        checkOutput("t4b_no_tasma", 32'(tasma_say - t0), 32'd0);
        checkOutput("t4b_data", 32'(veri_o), 32'h22);
        checkOutput("t4b_valid", 32'(veri_gecerli_o), 32'd1);

        // 5) reset during bit 4 of 0xFF
        per = int'(baud_div_i) + 1;
        driveBit(1'b0, per);
        for (int i = 0; i < 4; i++) driveBit(1'b1, per);
        rx_i = 1'b1;
        repeat (per / 2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("t5_rst_veri", 32'(veri_o), 32'd0);
        checkOutput("t5_rst_valid", 32'(veri_gecerli_o), 32'd0);
        checkOutput("t5_rst_busy", 32'(mesgul_o), 32'd0);
        repeat (2 * per) @(negedge clk_i);
        checkOutput("t5_aborted_nothing", 32'(veri_gecerli_o), 32'd0);
        applyStimulus(8'h00, 1'b1);
        repeat (4) @(negedge clk_i);
        checkOutput("t5_next_valid", 32'(veri_gecerli_o), 32'd1);
        checkOutput("t5_next_data", 32'(veri_o), 32'h00);
        ackOnce();

        // 6) back-to-back stream at the fastest and a slow bit period
        loopback(16'd3, "t6_b3");
        loopback(16'd867, "t6_b867");

        repeat (4) @(negedge clk_i);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
